spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- Transmit end of the pixel SPI link. Serializes BITS_PER_PIXEL-wide pixel words onto spi_clk/spi_mosi, MSB first, for the spi_slave receiver.
- The receiver samples spi_mosi on rising spi_clk and has no chip select, so word framing is purely a bit count from reset.
- Sits between the pixel source (valid/ready stream) and the board-level SPI pins. It derives spi_clk from the single system clock.

Parameters:
- BITS_PER_PIXEL, 32, word width and number of bits per SPI frame; must match the receiver.
- CLK_DIV, 2, system clock cycles per spi_clk half-period; legal range is 1 or greater.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- data_in, input, BITS_PER_PIXEL: pixel word; sampled only on handshake.
- data_valid, input, 1: data_in is valid.
- data_ready, output, 1: block can accept a word this cycle.
- spi_clk, output, 1: serial clock, idles low.
- spi_mosi, output, 1: serial data, MSB first.
- busy, output, 1: a word is being shifted out.
- word_done, output, 1: one-cycle pulse when the last bit of a word has completed its high phase.

Behaviour:
- All outputs are registered.
- Reset values: spi_clk=0, spi_mosi=0, busy=0, word_done=0, data_ready=0 during reset and 1 on the first cycle after it. State returns to IDLE; shift register, bit counter and divider counter clear to 0.
- Handshake: a word is accepted on a clk edge where data_valid && data_ready.
  - data_valid may deassert without a handshake.
  - data_in is ignored outside the accept edge.
- States:
  - IDLE: spi_clk=0, busy=0, data_ready=1. On accept, load the shift register, set bit count to 0 and go to LOW.
  - LOW: spi_clk=0, spi_mosi=shift[MSB], busy=1. Stay for CLK_DIV cycles, then go to HIGH.
  - HIGH: spi_clk=1, spi_mosi held stable, busy=1. Stay for CLK_DIV cycles, then:
    - If bit count < BITS_PER_PIXEL-1: shift left by 1, increment bit count, go to LOW.
    - Otherwise: pulse word_done for one cycle and go to IDLE (or reload, see the optional feature).
- Timing for an accept at edge N:
  - busy and the MSB on spi_mosi are visible from cycle N+1.
  - The first spi_clk rise is at cycle N+1+CLK_DIV.
  - A word occupies 2*CLK_DIV*BITS_PER_PIXEL cycles; 128 cycles at the defaults.
- spi_mosi changes only while spi_clk is low, or on the same edge spi_clk falls. It never changes on an spi_clk rise.
- Counter widths: $clog2(BITS_PER_PIXEL) for the bit counter and $clog2(CLK_DIV+1) for the divider. No wrap occurs before the terminal compare.
- Reset mid-word:
  - spi_clk goes low at the next edge and the partial word is discarded.
  - The system must also reset spi_slave, because the receiver's bit alignment is lost.
- Reset has priority over every other event, including a handshake on the same edge.
- After the last bit, spi_mosi holds its last value in IDLE.

Optional Feature:
- Macro: SPI_TX_PREFETCH_EN.
- Defined:
  - A one-word holding register is added. data_ready = !hold_full, including while busy.
  - At the end of the final HIGH phase, if hold_full, the shift register loads from hold, hold_full clears, and the state goes directly to LOW with no idle cycle. word_done still pulses.
  - Back-to-back words are gapless: spi_clk keeps an exact 2*CLK_DIV period across the word boundary.
  - An accept on the same edge the hold register drains is allowed; that word goes into hold.
  - Reset clears hold_full.
- Not defined: data_ready=1 only in IDLE. There is at least one idle cycle with spi_clk low between words.

Test Plan:
1. Reset for 2 cycles, then idle -> spi_clk=0, spi_mosi=0, busy=0, word_done=0; data_ready=1 after reset releases.
2. CLK_DIV=2: send 0xd0e0a0d0 -> exactly 32 spi_clk rising edges, 4 cycles apart. MOSI sampled at each rise gives d0e0a0d0 MSB first. word_done pulses once, 128 cycles after the first busy cycle. A spi_slave instance in the bench reports d0e0a0d0.
3. Three words 0xd0e0a0d0, 0xb0e0e0f0, 0x00000000 with data_valid held high -> the receiver reports all three in order. With SPI_TX_PREFETCH_EN, 96 contiguous rises and no gap; without it, at least one idle cycle between words.
4. CLK_DIV=1, BITS_PER_PIXEL=16, word 0xa5c3 -> spi_clk toggles every cycle, the 16 bits sampled are a5c3, and data_ready is low throughout the word (no-prefetch build).
5. Assert reset at bit 10 of 0xffffffff -> spi_clk=0 and busy=0 next cycle, no word_done, data_ready=1 after release. A following 0x12345678 is received correctly by a reset receiver.
6. Toggle data_valid for 1 cycle while busy (no-prefetch build) -> no handshake and no extra word. With SPI_TX_PREFETCH_EN the word is captured and sent next.

Source files
------------

// File: rtl/spi_master_tx.sv
// Pixel SPI transmitter: serializes BITS_PER_PIXEL-bit words MSB first on spi_clk/spi_mosi.
// Optional macro SPI_TX_PREFETCH_EN adds a one-word holding register for gapless back-to-back words.
module spi_master_tx #(
    parameter int BITS_PER_PIXEL = 32,
    parameter int CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BITS_PER_PIXEL-1:0] data_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic                      spi_clk,
    output logic                      spi_mosi,
    output logic                      busy,
    output logic                      word_done
);

    localparam int BW = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PIXEL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    logic [1:0]                state;
    logic [BITS_PER_PIXEL-1:0] shift;
    logic [BW-1:0]             bit_cnt;
    logic [DW-1:0]             div_cnt;

    logic accept;
    logic div_last;
    logic word_end;

    assign accept   = data_valid && data_ready;
    assign div_last = (div_cnt == DIV_LAST);
    assign word_end = (state == S_HIGH) && div_last && (bit_cnt == BIT_LAST);

`ifdef SPI_TX_PREFETCH_EN
    logic [BITS_PER_PIXEL-1:0] hold;
    logic                      hold_full;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            busy       <= 1'b0;
            word_done  <= 1'b0;
            data_ready <= 1'b0;
`ifdef SPI_TX_PREFETCH_EN
            hold       <= '0;
            hold_full  <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    spi_clk <= 1'b0;
                    busy    <= 1'b0;
                    if (accept) begin
                        shift    <= data_in;
                        spi_mosi <= data_in[BITS_PER_PIXEL-1];
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        spi_clk <= 1'b1;
                        state   <= S_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        spi_clk <= 1'b0;
                        if (bit_cnt != BIT_LAST) begin
                            // Next bit is presented on the same edge spi_clk falls.
                            shift    <= shift << 1;
                            spi_mosi <= shift[BITS_PER_PIXEL-2];
                            bit_cnt  <= bit_cnt + 1'b1;
                            state    <= S_LOW;
                        end else begin
                            word_done <= 1'b1;
`ifdef SPI_TX_PREFETCH_EN
                            if (hold_full) begin
                                shift    <= hold;
                                spi_mosi <= hold[BITS_PER_PIXEL-1];
                                bit_cnt  <= '0;
                                state    <= S_LOW;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
`else
                            busy  <= 1'b0;
                            state <= S_IDLE;
`endif
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

`ifdef SPI_TX_PREFETCH_EN
            // Words accepted while shifting park in hold; a same-edge drain and refill keeps it full.
            if (accept && (state != S_IDLE)) begin
                hold       <= data_in;
                hold_full  <= 1'b1;
                data_ready <= 1'b0;
            end else if (word_end && hold_full) begin
                hold_full  <= 1'b0;
                data_ready <= 1'b1;
            end else begin
                data_ready <= !hold_full;
            end
`else
            data_ready <= ((state == S_IDLE) && !accept) || word_end;
`endif
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx: 32-bit/CLK_DIV=2 instance plus a 16-bit/CLK_DIV=1 instance.
module tb_spi_master_tx;

    localparam int W  = 32;
    localparam int WB = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: 32 bits, CLK_DIV=2 ----------------
    logic [W-1:0] data_a  = '0;
    logic         valid_a = 1'b0;
    logic         ready_a, sclk_a, mosi_a, busy_a, done_a;

    spi_master_tx #(.BITS_PER_PIXEL(W), .CLK_DIV(2)) u_dut_a (
        .clk        (clk),
        .reset      (rst),
        .data_in    (data_a),
        .data_valid (valid_a),
        .data_ready (ready_a),
        .spi_clk    (sclk_a),
        .spi_mosi   (mosi_a),
        .busy       (busy_a),
        .word_done  (done_a)
    );

    // ---------------- DUT B: 16 bits, CLK_DIV=1 ----------------
    logic [WB-1:0] data_b  = '0;
    logic          valid_b = 1'b0;
    logic          ready_b, sclk_b, mosi_b, busy_b, done_b;

    spi_master_tx #(.BITS_PER_PIXEL(WB), .CLK_DIV(1)) u_dut_b (
        .clk        (clk),
        .reset      (rst),
        .data_in    (data_b),
        .data_valid (valid_b),
        .data_ready (ready_b),
        .spi_clk    (sclk_b),
        .spi_mosi   (mosi_b),
        .busy       (busy_b),
        .word_done  (done_b)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model for A: samples mosi on each spi_clk rise, frames by bit count from reset.
    int           rise_q[$];
    int           busy_q[$];
    int           done_q[$];
    int           rx_words    = 0;
    int           rx_cnt      = 0;
    logic [W-1:0] rx_sh       = '0;
    logic         prev_sclk_a = 1'b0;
    logic         prev_busy_a = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rx_cnt = 0;
            rx_sh  = '0;
        end else begin
            if (sclk_a && !prev_sclk_a) begin
                rise_q.push_back(cyc);
                rx_sh = {rx_sh[W-2:0], mosi_a};
                rx_cnt++;
                if (rx_cnt == W) begin
                    rx_cnt = 0;
                    rx_words++;
                    if (exp_q.size() == 0) check("rx_word_expected", 32'(exp_q.size()), 32'd1);
                    else                   check("rx_word", rx_sh, exp_q.pop_front());
                end
            end
            if (busy_a && !prev_busy_a) busy_q.push_back(cyc);
            if (done_a) done_q.push_back(cyc);
        end
        prev_sclk_a = sclk_a;
        prev_busy_a = busy_a;
    end

    // Monitor for B: received bits, toggle regularity and data_ready while busy.
    logic [WB-1:0] rx_b        = '0;
    int            rises_b     = 0;
    int            tog_bad     = 0;
    int            rdy_bad     = 0;
    logic          prev_sclk_b = 1'b0;
    logic          prev_busy_b = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy_b && prev_busy_b && (sclk_b == prev_sclk_b)) tog_bad++;
            if (busy_b && ready_b) rdy_bad++;
            if (sclk_b && !prev_sclk_b) begin
                rx_b = {rx_b[WB-2:0], mosi_b};
                rises_b++;
            end
        end
        prev_sclk_b = sclk_b;
        prev_busy_b = busy_b;
    end

    // ---------------- driver tasks ----------------
    task automatic send_a(input logic [W-1:0] w, input bit expect_rx);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        data_a  = w;
        valid_a = 1'b1;
        for (int n = 0; n < 2000 && !ok; n++) begin
            if (ready_a) begin
                @(posedge clk);
                ok = 1'b1;
                if (expect_rx) exp_q.push_back(w);
            end else begin
                @(negedge clk);
            end
        end
        check("accept_in_time", 32'(ok), 32'd1);
    endtask

    task automatic idle_a();
        @(negedge clk);
        valid_a = 1'b0;
        data_a  = $urandom;
    endtask

    task automatic wait_idle_a(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            @(negedge clk);
            if (!busy_a) break;
        end
        check("idle_in_time", 32'(busy_a), 32'd0);
    endtask

    task automatic gap_stats(input int from, output int mn, output int mx);
        mn = 1000000;
        mx = 0;
        for (int i = from + 1; i < rise_q.size(); i++) begin
            if (rise_q[i] - rise_q[i-1] < mn) mn = rise_q[i] - rise_q[i-1];
            if (rise_q[i] - rise_q[i-1] > mx) mx = rise_q[i] - rise_q[i-1];
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    int r0, b0, d0, w0, rb0, mn, mx, lat;

    initial begin
        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_spi_clk",    32'(sclk_a),  32'd0);
        check("rst_spi_mosi",   32'(mosi_a),  32'd0);
        check("rst_busy",       32'(busy_a),  32'd0);
        check("rst_word_done",  32'(done_a),  32'd0);
        check("rst_data_ready", 32'(ready_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_a), 32'd1);
        check("idle_spi_clk",      32'(sclk_a),  32'd0);
        check("idle_busy",         32'(busy_a),  32'd0);

        // Single word, timing and bit order
        r0 = rise_q.size(); b0 = busy_q.size(); d0 = done_q.size(); w0 = rx_words;
        send_a(32'hd0e0a0d0, 1'b1);
        idle_a();
        wait_idle_a(400);
        repeat (4) @(negedge clk);
        check("t2_rises", 32'(rise_q.size() - r0), 32'd32);
        gap_stats(r0, mn, mx);
        check("t2_min_period", 32'(mn), 32'd4);
        check("t2_max_period", 32'(mx), 32'd4);
        check("t2_done_count", 32'(done_q.size() - d0), 32'd1);
        lat = (done_q.size() > d0 && busy_q.size() > b0) ? done_q[d0] - busy_q[b0] : -1;
        check("t2_done_latency", 32'(lat), 32'd128);
        lat = (rise_q.size() > r0 && busy_q.size() > b0) ? rise_q[r0] - busy_q[b0] : -1;
        check("t2_first_rise", 32'(lat), 32'd2);
        check("t2_rx_words", 32'(rx_words - w0), 32'd1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Three words with data_valid held high
        r0 = rise_q.size(); d0 = done_q.size(); w0 = rx_words;
        send_a(32'hd0e0a0d0, 1'b1);
        send_a(32'hb0e0e0f0, 1'b1);
        send_a(32'h00000000, 1'b1);
        idle_a();
        wait_idle_a(1000);
        repeat (4) @(negedge clk);
        check("t3_rises", 32'(rise_q.size() - r0), 32'd96);
        gap_stats(r0, mn, mx);
`ifdef SPI_TX_PREFETCH_EN
        check("t3_gapless_max_period", 32'(mx), 32'd4);
`else
        check("t3_idle_gap", 32'(mx > 4), 32'd1);
`endif
        check("t3_min_period", 32'(mn), 32'd4);
        check("t3_done_count", 32'(done_q.size() - d0), 32'd3);
        check("t3_rx_words", 32'(rx_words - w0), 32'd3);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 16-bit instance at CLK_DIV=1
        rb0 = rises_b;
        @(negedge clk);
        data_b  = 16'ha5c3;
        valid_b = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (ready_b) break;
            @(negedge clk);
        end
        @(negedge clk);
        valid_b = 1'b0;
        data_b  = 16'(($urandom));
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy_b) break;
        end
        check("t4_idle", 32'(busy_b), 32'd0);
        check("t4_rises", 32'(rises_b - rb0), 32'd16);
        check("t4_rx_word", 32'(rx_b), 32'h0000a5c3);
        check("t4_toggle_every_cycle", 32'(tog_bad), 32'd0);
`ifndef SPI_TX_PREFETCH_EN
        check("t4_ready_low_while_busy", 32'(rdy_bad), 32'd0);
`endif

        // Reset in the middle of a word
        r0 = rise_q.size(); d0 = done_q.size(); w0 = rx_words;
        send_a(32'hffffffff, 1'b0);
        idle_a();
        for (int n = 0; n < 500; n++) begin
            if (rise_q.size() - r0 >= 10) break;
            @(negedge clk);
        end
        check("t5_reached_bit10", 32'(rise_q.size() - r0), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check("t5_spi_clk_low",  32'(sclk_a), 32'd0);
        check("t5_busy_low",     32'(busy_a), 32'd0);
        check("t5_no_word_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after_release", 32'(ready_a), 32'd1);
        check("t5_done_count", 32'(done_q.size() - d0), 32'd0);
        send_a(32'h12345678, 1'b1);
        idle_a();
        wait_idle_a(400);
        repeat (4) @(negedge clk);
        check("t5_rx_words", 32'(rx_words - w0), 32'd1);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // One-cycle data_valid pulse while busy
        b0 = busy_q.size(); w0 = rx_words;
        send_a(32'h5a5a5a5b, 1'b1);
        idle_a();
        repeat (20) @(negedge clk);
        data_a  = 32'hdeadbeef;
        valid_a = 1'b1;
`ifdef SPI_TX_PREFETCH_EN
        check("t6_ready_while_busy", 32'(ready_a), 32'd1);
        exp_q.push_back(32'hdeadbeef);
`else
        check("t6_ready_while_busy", 32'(ready_a), 32'd0);
`endif
        @(negedge clk);
        valid_a = 1'b0;
        wait_idle_a(600);
        repeat (150) @(negedge clk);
        check("t6_busy_episodes", 32'(busy_q.size() - b0), 32'd1);
`ifdef SPI_TX_PREFETCH_EN
        check("t6_rx_words", 32'(rx_words - w0), 32'd2);
`else
        check("t6_rx_words", 32'(rx_words - w0), 32'd1);
`endif
        check("t6_mosi_holds_last", 32'(mosi_a), 32'd1);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
